// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel timing from an asynchronous VGA stream, locks onto the
// configured line/frame geometry and emits active-area pixels with coordinates.
module vga_sync_rx #(
  parameter int CLK_PER_PIX = 8,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [2:0] i_r,
  input  logic [2:0] i_g,
  input  logic [1:0] i_b,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic [7:0] o_pix_rgb,
  output logic       o_pix_valid,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_sync_err
);
  localparam int PW = $clog2(CLK_PER_PIX);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t r_state, w_next;
  logic [1:0] r_hs, r_vs;
  logic [7:0] r_rgb1, r_rgb2;
  logic r_hs_d, r_vs_at_rise;
  logic [PW-1:0] r_phase;
  logic [9:0] r_tick, r_line, r_vs_cnt, r_good, w_good_next, w_good_inc;
  logic w_rise, w_fall, w_tick, w_fs, w_err, w_act;
  assign w_rise = r_hs[1] & ~r_hs_d;
  assign w_fall = ~r_hs[1] & r_hs_d;
  // the rise cycle restarts the phase, so it never counts as a sample point
  assign w_tick = ~w_rise & (r_phase == PW'(CLK_PER_PIX / 2));
  assign w_fs = w_rise & r_vs[1] & ~r_vs_at_rise;
  assign w_err = (w_rise & (r_tick != 10'(H_TOTAL)))
               | (w_fall & (r_tick != 10'(H_SYNC)))
               | (w_tick & (r_tick == 10'(H_TOTAL + 15)))
               | (w_fs & ((r_line != 10'(V_TOTAL - 1)) | (r_vs_cnt != 10'(V_SYNC))));
  assign w_act = (r_state == LOCKED) & w_tick
               & (r_tick >= 10'(H_ACT_START)) & (r_tick < 10'(H_ACT_END))
               & (r_line >= 10'(V_ACT_START)) & (r_line < 10'(V_ACT_END));
  assign w_good_inc = r_good + 10'd1;
  assign o_locked = (r_state == LOCKED);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs <= '0;
      r_vs <= '0;
      r_rgb1 <= '0;
      r_rgb2 <= '0;
      r_hs_d <= 1'b0;
      r_vs_at_rise <= 1'b0;
      r_phase <= '0;
      r_tick <= '0;
      r_line <= '0;
      r_vs_cnt <= '0;
      o_pix_x <= '0;
      o_pix_y <= '0;
      o_pix_rgb <= '0;
      o_pix_valid <= 1'b0;
      o_frame_start <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      r_hs <= {r_hs[0], i_hsync};
      r_vs <= {r_vs[0], i_vsync};
      r_rgb1 <= {i_r, i_g, i_b};
      r_rgb2 <= r_rgb1;
      r_hs_d <= r_hs[1];
      if (w_rise) begin
        r_phase <= '0;
        r_tick <= '0;
        r_vs_at_rise <= r_vs[1];
        r_line <= w_fs ? '0 : r_line + 10'(r_line != '1);
        // the frame-start rise itself is the first vsync-high line of the new frame
        r_vs_cnt <= w_fs ? 10'd1 : r_vs_cnt + 10'(r_vs[1] && r_vs_cnt != '1);
      end else begin
        r_phase <= (r_phase == PW'(CLK_PER_PIX - 1)) ? '0 : r_phase + 1'b1;
        r_tick <= r_tick + 10'(w_tick && r_tick != '1);
      end
      o_pix_valid <= w_act;
      if (w_act) begin
        o_pix_x <= r_tick - 10'(H_ACT_START);
        o_pix_y <= r_line - 10'(V_ACT_START);
        o_pix_rgb <= r_rgb2;
      end
      o_frame_start <= w_fs;
      o_sync_err <= w_err & (r_state != SEARCH);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
      r_good <= '0;
    end else begin
      r_state <= w_next;
      r_good <= w_good_next;
    end
  end
  always_comb begin
    w_next = r_state;
    w_good_next = r_good;
    if (r_state == SEARCH) begin
      w_next = w_fs ? TRACK : SEARCH;
      w_good_next = w_fs ? '0 : r_good;
    end else if (w_err) begin
      w_next = SEARCH;
    end else if (r_state == TRACK && w_fs) begin
      w_good_next = w_good_inc;
      w_next = (w_good_inc >= 10'(LOCK_FRAMES)) ? LOCKED : TRACK;
    end
  end
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a reduced-geometry VGA stream with directed faults; a queue
// scoreboard checks every emitted pixel (content and arrival cycle) plus lock/error timing.
module tb_vga_sync_rx;
  localparam int CPP = 4, HT = 20, HS = 3, HA0 = 5, HA1 = 17;
  localparam int VT = 10, VS = 2, VA0 = 3, VA1 = 8;
  logic clk = 0, rst = 1, hs = 0, vs = 0;
  logic [2:0] r = 0, g = 0;
  logic [1:0] b = 0;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_rgb;
  logic pix_valid, frame_start, locked, sync_err;

  vga_sync_rx #(
    .CLK_PER_PIX(CPP), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .i_hsync(hs), .i_vsync(vs), .i_r(r), .i_g(g), .i_b(b),
    .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_rgb(pix_rgb), .o_pix_valid(pix_valid),
    .o_frame_start(frame_start), .o_locked(locked), .o_sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; logic [7:0] rgb; int t;} pix_t;
  pix_t sb[$];
  pix_t e;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int err_n = 0, err_cyc = -1, lock_rise = -1, lock_fall = -1, fs_n = 0, val_n = 0;
  logic prev_lock = 0;
  int frame_no = 0, lock_from = 2, ls_cyc = 0, prev_ls = 0, fs_cyc = 0, exp_err = 0, exp_err_n = 0;
  bit kill = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      val_n++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h at cycle %0d, expected no pixel", pix_x, pix_y, pix_rgb, cyc);
      end else begin
        e = sb.pop_front();
        if (e.x != int'(pix_x) || e.y != int'(pix_y) || e.rgb != pix_rgb || e.t != cyc) begin
          n_bad++;
          $display("FAIL pix: got x=%0d y=%0d rgb=%h cyc=%0d, expected x=%0d y=%0d rgb=%h cyc=%0d",
                   pix_x, pix_y, pix_rgb, cyc, e.x, e.y, e.rgb, e.t);
        end
      end
    end
    if (sync_err) begin
      err_n++;
      err_cyc = cyc;
    end
    if (frame_start) fs_n++;
    if (locked && !prev_lock) lock_rise = cyc;
    if (!locked && prev_lock) lock_fall = cyc;
    prev_lock = locked;
  end

  function automatic logic [7:0] rgb_of(input int p, input int l);
    return (p == HA0 && l == VA0) ? 8'hE0 : 8'((p * 37 + l * 11) ^ 8'h5A);
  endfunction

  // kind: 0 nominal, 1 line one pixel long, 2 hsync one pixel short,
  //       3 reset pulse mid-frame, 4 line with no hsync pulse
  task automatic send_frame(input int kind, input int bl);
    int v0;
    v0 = val_n;
    kill = 0;
    for (int l = 0; l < VT; l++) begin
      int np = (kind == 1 && l == bl) ? HT + 1 : HT;
      int hw = (kind == 2 && l == bl) ? HS - 1 : (kind == 4 && l == bl) ? 0 : HS;
      if (kind == 4 && l == bl) kill = 1;
      for (int p = 0; p < np; p++) begin
        for (int c = 0; c < CPP; c++) begin
          @(negedge clk);
          if (c == 0) begin
            hs = (p < hw);
            vs = (l < VS);
            {r, g, b} = rgb_of(p, l);
            if (p == 0) begin
              prev_ls = ls_cyc;
              ls_cyc = cyc;
              if (l == 0) fs_cyc = cyc;
              if (kind == 2 && l == bl) exp_err = ls_cyc + (HS - 1) * CPP + 3;
              if (kind == 4 && l == bl) exp_err = prev_ls + 6 + (HT + 15) * CPP;
              if (kind == 1 && l == bl + 1) exp_err = ls_cyc + 3;
            end
            if (frame_no >= lock_from && !kill && p >= HA0 && p < HA1 && l >= VA0 && l < VA1)
              sb.push_back('{p - HA0, l - VA0, rgb_of(p, l), cyc + 6});
          end
          if (kind == 3 && l == bl && p == HT - 1 && c == 1) begin
            chk("pre_rst_locked", int'(locked), 1);
            rst = 1;
          end
          if (kind == 3 && l == bl && p == HT - 1 && c == 2) begin
            rst = 0;
            kill = 1;
            chk("rst_locked", int'(locked), 0);
            chk("rst_pix_x", int'(pix_x), 0);
            chk("rst_pix_y", int'(pix_y), 0);
            chk("rst_pix_rgb", int'(pix_rgb), 0);
            chk("rst_valid", int'(pix_valid), 0);
            chk("rst_sync_err", int'(sync_err), 0);
          end
        end
      end
      if (kind == 1 && l == bl) kill = 1;
    end
    chk("locked_end_of_frame", int'(locked), int'(frame_no >= lock_from && !kill));
    chk("frame_start_count", fs_n, frame_no + 1);
    if (frame_no == lock_from) chk("lock_rise_cycle", lock_rise, fs_cyc + 3);
    if (kind == 0 && frame_no >= lock_from) chk("pixels_per_frame", val_n - v0, (HA1 - HA0) * (VA1 - VA0));
    if (kind == 1 || kind == 2 || kind == 4) begin
      exp_err_n++;
      chk("sync_err_cycle", err_cyc, exp_err);
      chk("sync_err_count", err_n, exp_err_n);
      if (kind != 2) chk("lock_fall_cycle", lock_fall, exp_err);
    end
    if (kind == 3) chk("no_err_on_reset", err_n, exp_err_n);
    if (kind != 0) lock_from = frame_no + 3;
    frame_no++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_locked", int'(locked), 0);
    chk("reset_valid", int'(pix_valid), 0);
    chk("reset_sync_err", int'(sync_err), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_pix_x", int'(pix_x), 0);
    chk("reset_pix_y", int'(pix_y), 0);
    chk("reset_pix_rgb", int'(pix_rgb), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    send_frame(0, 0);
    send_frame(0, 0);
    send_frame(0, 0);
    send_frame(0, 0);
    send_frame(1, 4);
    send_frame(0, 0);
    send_frame(2, 4);
    repeat (3) send_frame(0, 0);
    send_frame(3, 5);
    repeat (3) send_frame(0, 0);
    send_frame(4, 6);
    repeat (3) send_frame(0, 0);
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_sync_err", err_n, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
